// File: rtl/branch_redirect_arbiter.sv
// branch_redirect_arbiter
//   Collects branch writebacks from all ALU/BRU pipes, picks the oldest
//   mispredicted branch and holds it as a single pending redirect towards the
//   frontend / ROB squash logic (valid/ready). Mispredicts younger than the
//   redirect in flight, or younger than the one already pending, are dropped
//   because the squash will remove them anyway.
//
//   Optional feature: define BRANCH_REDIRECT_PERF_EN to add three 32-bit
//   saturating performance counters (o_perf_mispred, o_perf_redirect,
//   o_perf_dropped). They are cleared by rst only, not by i_flush.
//
//   Reset: synchronous, active-high rst.

module branch_redirect_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ROB_W     = 6,
  parameter int FTQ_W     = 4,
  parameter int XLEN      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           i_bwb_vld,
  input  logic [NUM_PORTS-1:0]           i_bwb_mispred,
  input  logic [NUM_PORTS*(ROB_W+1)-1:0] i_bwb_rob_idx,
  input  logic [NUM_PORTS*FTQ_W-1:0]     i_bwb_ftq_idx,
  input  logic [NUM_PORTS-1:0]           i_bwb_taken,
  input  logic [NUM_PORTS*XLEN-1:0]      i_bwb_npc,
  input  logic [NUM_PORTS*3-1:0]         i_bwb_type,
  input  logic                           i_flush,
  input  logic                           i_squash_done,
  output logic                           o_redirect_vld,
  input  logic                           i_redirect_rdy,
  output logic [ROB_W:0]                 o_redirect_rob_idx,
  output logic [FTQ_W-1:0]               o_redirect_ftq_idx,
  output logic [XLEN-1:0]                o_redirect_npc,
  output logic                           o_redirect_taken,
  output logic [2:0]                     o_redirect_type,
  output logic                           o_squash_active
`ifdef BRANCH_REDIRECT_PERF_EN
  ,
  output logic [31:0]                    o_perf_mispred,
  output logic [31:0]                    o_perf_redirect,
  output logic [31:0]                    o_perf_dropped
`endif
);

  localparam int RW = ROB_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [RW-1:0]    rob;
    logic [FTQ_W-1:0] ftq;
    logic [XLEN-1:0]  npc;
    logic             taken;
    logic [2:0]       btype;
  } redirect_t;

  // a is older than b; the wrap flag flips the sense of the index compare.
  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] < b[ROB_W-1:0];
    else                      return a[ROB_W-1:0] > b[ROB_W-1:0];
  endfunction

  state_e          state_q, state_d;
  redirect_t       pend_q, pend_d;
  logic [RW-1:0]   last_rob_q, last_rob_d;
  logic            squash_active_q, squash_active_d;

  redirect_t              bwb [NUM_PORTS];
  logic [NUM_PORTS-1:0]   cand;
  logic [NUM_PORTS-1:0]   survive;
  redirect_t              win;
  logic                   win_vld;
  logic                   hs;

  // Unpack the per-port buses and filter candidates that will be squashed anyway.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed; only clocked blocks use '<='.
    for (int p = 0; p < NUM_PORTS; p++) begin
      bwb[p].rob   = i_bwb_rob_idx[p*RW +: RW];
      bwb[p].ftq   = i_bwb_ftq_idx[p*FTQ_W +: FTQ_W];
      bwb[p].npc   = i_bwb_npc[p*XLEN +: XLEN];
      bwb[p].taken = i_bwb_taken[p];
      bwb[p].btype = i_bwb_type[p*3 +: 3];
      cand[p]      = i_bwb_vld[p] && i_bwb_mispred[p];
      survive[p]   = cand[p]
                   && (!squash_active_q || older(bwb[p].rob, last_rob_q))
                   && ((state_q != S_HOLD) || older(bwb[p].rob, pend_q.rob));
    end
  end

  // Oldest surviving candidate; a strict compare keeps the lowest port on a tie.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (survive[p] && (!win_vld || older(bwb[p].rob, win.rob))) begin
        win_vld = 1'b1;
        win     = bwb[p];
      end
    end
  end

  assign hs = (state_q == S_HOLD) && i_redirect_rdy;

  // Next-state logic: pending entry, handshake bookkeeping, flush priority.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    pend_d          = pend_q;
    last_rob_d      = last_rob_q;
    squash_active_d = squash_active_q && !i_squash_done;

    if (i_flush) begin
      state_d         = S_IDLE;
      squash_active_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            pend_d  = win;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (hs) begin
            last_rob_d      = pend_q.rob;
            squash_active_d = 1'b1;
            state_d         = win_vld ? S_HOLD : S_IDLE;
          end
          if (win_vld) pend_d = win;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    // NOTE: the pending payload is reset too (not just the valid state) because
    // every output, including the redirect fields, must read zero out of reset.
    if (rst) begin
      state_q         <= S_IDLE;
      pend_q          <= '0;
      last_rob_q      <= '0;
      squash_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      last_rob_q      <= last_rob_d;
      squash_active_q <= squash_active_d;
    end
  end

  assign o_redirect_vld     = (state_q == S_HOLD);
  assign o_redirect_rob_idx = pend_q.rob;
  assign o_redirect_ftq_idx = pend_q.ftq;
  assign o_redirect_npc     = pend_q.npc;
  assign o_redirect_taken   = pend_q.taken;
  assign o_redirect_type    = pend_q.btype;
  assign o_squash_active    = squash_active_q;

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [31:0] perf_mispred_q, perf_mispred_d;
  logic [31:0] perf_redirect_q, perf_redirect_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] cand_cnt;
  logic [31:0] dropped_inc;
  logic        win_load;
  logic        replaced;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Event counts: every candidate not loaded as pending, plus any pending entry
  // overwritten before being handed off, counts as dropped. A handshake in a
  // flush cycle is discarded and therefore not counted as a redirect.
  always_comb begin
    cand_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) cand_cnt = cand_cnt + {31'd0, cand[p]};
    win_load        = win_vld && !i_flush;
    replaced        = (state_q == S_HOLD) && !hs && win_vld && !i_flush;
    dropped_inc     = cand_cnt - {31'd0, win_load} + {31'd0, replaced};
    perf_mispred_d  = sat_add(perf_mispred_q, cand_cnt);
    perf_redirect_d = sat_add(perf_redirect_q, {31'd0, hs && !i_flush});
    perf_dropped_d  = sat_add(perf_dropped_q, dropped_inc);
  end

  // Counter registers, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mispred_q  <= '0;
      perf_redirect_q <= '0;
      perf_dropped_q  <= '0;
    end else begin
      perf_mispred_q  <= perf_mispred_d;
      perf_redirect_q <= perf_redirect_d;
      perf_dropped_q  <= perf_dropped_d;
    end
  end

  assign o_perf_mispred  = perf_mispred_q;
  assign o_perf_redirect = perf_redirect_q;
  assign o_perf_dropped  = perf_dropped_q;
`endif

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Self-checking bench for branch_redirect_arbiter: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model that
// judges age by modular distance in the wrapped ROB index space.

module tb_branch_redirect_arbiter;

  localparam int NP    = 2;
  localparam int ROB_W = 6;
  localparam int FTQ_W = 4;
  localparam int XLEN  = 64;
  localparam int RW    = ROB_W + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           bwb_vld;
  logic [NP-1:0]           bwb_mispred;
  logic [NP*RW-1:0]        bwb_rob;
  logic [NP*FTQ_W-1:0]     bwb_ftq;
  logic [NP-1:0]           bwb_taken;
  logic [NP*XLEN-1:0]      bwb_npc;
  logic [NP*3-1:0]         bwb_type;
  logic                    flush;
  logic                    squash_done;
  logic                    rdy;
  logic                    o_vld;
  logic [RW-1:0]           o_rob;
  logic [FTQ_W-1:0]        o_ftq;
  logic [XLEN-1:0]         o_npc;
  logic                    o_taken;
  logic [2:0]              o_type;
  logic                    o_sq;

  int checks = 0;
  int errors = 0;

  // Reference model state: one pending redirect plus squash tracking.
  bit              m_pv;
  logic [RW-1:0]   m_prob;
  logic [FTQ_W-1:0] m_pftq;
  logic [XLEN-1:0] m_pnpc;
  logic            m_ptaken;
  logic [2:0]      m_ptype;
  logic [RW-1:0]   m_last;
  bit              m_sq;

  branch_redirect_arbiter #(
    .NUM_PORTS(NP), .ROB_W(ROB_W), .FTQ_W(FTQ_W), .XLEN(XLEN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_bwb_vld         (bwb_vld),
    .i_bwb_mispred     (bwb_mispred),
    .i_bwb_rob_idx     (bwb_rob),
    .i_bwb_ftq_idx     (bwb_ftq),
    .i_bwb_taken       (bwb_taken),
    .i_bwb_npc         (bwb_npc),
    .i_bwb_type        (bwb_type),
    .i_flush           (flush),
    .i_squash_done     (squash_done),
    .o_redirect_vld    (o_vld),
    .i_redirect_rdy    (rdy),
    .o_redirect_rob_idx(o_rob),
    .o_redirect_ftq_idx(o_ftq),
    .o_redirect_npc    (o_npc),
    .o_redirect_taken  (o_taken),
    .o_redirect_type   (o_type),
    .o_squash_active   (o_sq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Age by modular distance: a is older when b lies 1..half-window ahead of it.
  function automatic bit m_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] d;
    d = b - a;
    return (d != '0) && (d < RW'(1 << ROB_W));
  endfunction

  task automatic model_update();
    bit            hs;
    bit            have;
    int            best;
    bit            nsq;
    logic [RW-1:0] r;
    logic [RW-1:0] rb;
    if (rst) begin
      m_pv = 0; m_sq = 0; m_last = '0;
      m_prob = '0; m_pftq = '0; m_pnpc = '0; m_ptaken = 0; m_ptype = '0;
      return;
    end
    if (flush) begin
      m_pv = 0; m_sq = 0;
      return;
    end
    hs   = m_pv && rdy;
    have = 0;
    best = 0;
    rb   = '0;
    for (int p = 0; p < NP; p++) begin
      if (!(bwb_vld[p] && bwb_mispred[p])) continue;
      r = bwb_rob[p*RW +: RW];
      if (m_sq && !m_older(r, m_last)) continue;
      if (m_pv && !m_older(r, m_prob)) continue;
      if (!have || m_older(r, rb)) begin
        have = 1; best = p; rb = r;
      end
    end
    nsq = m_sq && !squash_done;
    if (hs) begin
      m_last = m_prob;
      nsq    = 1;
    end
    if (have) begin
      m_pv     = 1;
      m_prob   = rb;
      m_pftq   = bwb_ftq[best*FTQ_W +: FTQ_W];
      m_pnpc   = bwb_npc[best*XLEN +: XLEN];
      m_ptaken = bwb_taken[best];
      m_ptype  = bwb_type[best*3 +: 3];
    end else if (hs) begin
      m_pv = 0;
    end
    m_sq = nsq;
  endtask

  task automatic compare_model();
    check("vld", 64'(o_vld), 64'(m_pv));
    check("squash_active", 64'(o_sq), 64'(m_sq));
    if (m_pv) begin
      check("rob", 64'(o_rob), 64'(m_prob));
      check("ftq", 64'(o_ftq), 64'(m_pftq));
      check("npc", o_npc, m_pnpc);
      check("taken", 64'(o_taken), 64'(m_ptaken));
      check("type", 64'(o_type), 64'(m_ptype));
    end
  endtask

  // One clock: DUT and model both consume the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic clear_bwb();
    bwb_vld = '0; bwb_mispred = '0; bwb_rob = '0; bwb_ftq = '0;
    bwb_taken = '0; bwb_npc = '0; bwb_type = '0;
    flush = 0; squash_done = 0;
  endtask

  task automatic drive(input int p, input logic [RW-1:0] rob, input logic [63:0] npc);
    bwb_vld[p]               = 1'b1;
    bwb_mispred[p]           = 1'b1;
    bwb_rob[p*RW +: RW]      = rob;
    bwb_ftq[p*FTQ_W +: FTQ_W] = rob[FTQ_W-1:0];
    bwb_npc[p*XLEN +: XLEN]  = npc;
    bwb_taken[p]             = 1'b1;
    bwb_type[p*3 +: 3]       = 3'd2;
  endtask

  // Handshake away whatever is pending, then finish its squash.
  task automatic drain();
    clear_bwb(); rdy = 1; step();
    squash_done = 1; step();
    squash_done = 0;
  endtask

  initial begin
    logic [RW-1:0] rv [NP];
    bit            dup;
    rst = 1; rdy = 0; clear_bwb();
    step(); step();
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_sq", 64'(o_sq), 64'd0);
    check("rst_rob", 64'(o_rob), 64'd0);
    check("rst_npc", o_npc, 64'd0);
    check("rst_ftq_type_taken", 64'({o_ftq, o_type, o_taken}), 64'd0);
    rst = 0;
    step();

    // Single mispredict, one-cycle latency, then squash lifecycle.
    rdy = 1; drive(0, 7'd5, 64'h8000_0100); step();
    check("single_vld", 64'(o_vld), 64'd1);
    check("single_rob", 64'(o_rob), 64'd5);
    check("single_npc", o_npc, 64'h8000_0100);
    clear_bwb(); step();
    check("single_hs_vld", 64'(o_vld), 64'd0);
    check("single_sq_set", 64'(o_sq), 64'd1);
    squash_done = 1; step();
    check("single_sq_clr", 64'(o_sq), 64'd0);
    squash_done = 0;

    // Two ports in one cycle: older wins.
    rdy = 0; drive(0, 7'd9, 64'h1000); drive(1, 7'd3, 64'h2000); step();
    check("two_port_rob", 64'(o_rob), 64'd3);
    clear_bwb(); step();
    check("two_port_hold", 64'(o_rob), 64'd3);
    drain();

    // Wrap: {1,2} replaced by older {0,60}; younger {1,1} ignored.
    rdy = 0; clear_bwb(); drive(0, 7'h42, 64'h3000); step();
    check("wrap_first", 64'(o_rob), 64'h42);
    clear_bwb(); drive(1, 7'd60, 64'h4000); step();
    check("wrap_replace", 64'(o_rob), 64'd60);
    clear_bwb(); drive(0, 7'h41, 64'h5000); step();
    check("wrap_ignore", 64'(o_rob), 64'd60);
    check("wrap_npc", o_npc, 64'h4000);
    drain();

    // Squash filter against last_rob {0,10}.
    rdy = 1; clear_bwb(); drive(0, 7'd10, 64'h6000); step();
    clear_bwb(); step();
    check("sq_active", 64'(o_sq), 64'd1);
    drive(0, 7'd12, 64'h7000); step();
    check("sq_drop_young", 64'(o_vld), 64'd0);
    clear_bwb(); drive(1, 7'd8, 64'h8000); step();
    check("sq_pass_old_vld", 64'(o_vld), 64'd1);
    check("sq_pass_old_rob", 64'(o_rob), 64'd8);
    drain();

    // Handshake with a simultaneous older winner keeps vld high.
    rdy = 0; clear_bwb(); drive(0, 7'd4, 64'h9000); step();
    rdy = 1; clear_bwb(); drive(1, 7'd1, 64'hA000); step();
    check("hs_older_vld", 64'(o_vld), 64'd1);
    check("hs_older_rob", 64'(o_rob), 64'd1);
    check("hs_older_sq", 64'(o_sq), 64'd1);
    drain();

    // Flush in HOLD with a candidate in the same cycle.
    rdy = 0; clear_bwb(); drive(0, 7'd20, 64'hB000); step();
    clear_bwb(); flush = 1; drive(1, 7'd15, 64'hC000); step();
    check("flush_vld", 64'(o_vld), 64'd0);
    check("flush_sq", 64'(o_sq), 64'd0);
    clear_bwb(); rdy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet", 64'(o_vld), 64'd0);
    end

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_bwb();
      for (int p = 0; p < NP; p++) begin
        do begin
          rv[p] = RW'($urandom_range(0, (1 << RW) - 1));
          dup = 0;
          for (int q = 0; q < p; q++)
            if (rv[q][ROB_W-1:0] == rv[p][ROB_W-1:0]) dup = 1;
        end while (dup);
        bwb_vld[p]                = ($urandom_range(0, 9) < 7);
        bwb_mispred[p]            = ($urandom_range(0, 9) < 4);
        bwb_rob[p*RW +: RW]       = rv[p];
        bwb_ftq[p*FTQ_W +: FTQ_W] = FTQ_W'($urandom);
        bwb_npc[p*XLEN +: XLEN]   = {$urandom, $urandom};
        bwb_taken[p]              = 1'($urandom);
        bwb_type[p*3 +: 3]        = 3'($urandom);
      end
      rdy         = ($urandom_range(0, 9) < 4);
      squash_done = ($urandom_range(0, 9) < 2);
      flush       = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_arbiter.md
Name: branch_redirect_arbiter

Overview:
- Collects branch writebacks from all ALU/BRU pipes and selects the oldest mispredicted branch.
- Holds that branch as a single pending redirect and presents it to the frontend/ROB squash logic with a valid/ready handshake.
- Drops mispredicts that will be squashed anyway, i.e. those younger than a redirect in flight.
- Sits between the BRU writeback stage and the frontend redirect/FTQ update path.

Parameters:
- NUM_PORTS, 2, number of ALU/BRU branch writeback ports.
- ROB_W, 6, ROB index bits, excluding the wrap flag.
- FTQ_W, 4, FTQ index bits.
- XLEN, 64, PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_bwb_vld  in  NUM_PORTS  per-port branch writeback valid
- i_bwb_mispred  in  NUM_PORTS  per-port has_mispred
- i_bwb_rob_idx  in  NUM_PORTS*(ROB_W+1)  per-port {wrap flag, index}
- i_bwb_ftq_idx  in  NUM_PORTS*FTQ_W  per-port FTQ index
- i_bwb_taken  in  NUM_PORTS  per-port branch taken
- i_bwb_npc  in  NUM_PORTS*XLEN  per-port resolved next PC
- i_bwb_type  in  NUM_PORTS*3  per-port BranchType encoding
- i_flush  in  1  global flush (exception/interrupt)
- i_squash_done  in  1  backend finished squashing the last redirect
- o_redirect_vld  out  1  pending redirect valid
- i_redirect_rdy  in  1  consumer accepts the redirect
- o_redirect_rob_idx  out  ROB_W+1  redirect ROB index
- o_redirect_ftq_idx  out  FTQ_W  redirect FTQ index
- o_redirect_npc  out  XLEN  redirect target PC
- o_redirect_taken  out  1  redirect taken bit
- o_redirect_type  out  3  redirect BranchType
- o_squash_active  out  1  a redirect has been sent and its squash is not yet done

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. During reset all outputs are 0, the FSM goes to IDLE and squash_active is cleared.
- Age compare, older(a,b):
  - if a.flag == b.flag, a is older when a.idx < b.idx;
  - otherwise a is older when a.idx > b.idx;
  - equal indices are not older.
- Candidate on port p: i_bwb_vld[p] && i_bwb_mispred[p].
- Candidate filtering:
  - While squash_active, drop any candidate that is not older than last_rob.
  - While in HOLD, drop any candidate that is not older than the pending entry.
- Port selection: the oldest surviving candidate wins. On an equal rob_idx the lowest port wins; the bench treats this as an error.
- FSM IDLE:
  - A winner registers into pending; go to HOLD.
  - o_redirect_vld rises the next cycle, so latency is one cycle from writeback to redirect.
- FSM HOLD:
  - o_redirect_vld = 1, driving pending fields. Outputs stay stable unless an older winner replaces them.
  - Handshake (vld && rdy):
    - set last_rob = pending.rob and set squash_active;
    - if a winner exists this cycle that is older than pending, load it and stay in HOLD;
    - otherwise go to IDLE.
  - No handshake with an older winner: replace pending in place and stay in HOLD.
- i_squash_done clears squash_active. If a handshake happens in the same cycle, the handshake wins and squash_active stays 1.
- i_flush has priority over everything:
  - next cycle FSM is IDLE, o_redirect_vld = 0, squash_active = 0;
  - candidates in the flush cycle are discarded.
- Non-mispredicted writebacks are ignored by this block.
- ROB wrap: the flag bit makes comparison correct across the index wrap.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_EN.
- When defined, three 32-bit saturating counters are added, readable via outputs o_perf_mispred, o_perf_redirect, o_perf_dropped:
  - o_perf_mispred increments by the popcount of candidates per cycle;
  - o_perf_redirect increments on each handshake;
  - o_perf_dropped increments by the count of filtered or replaced candidates.
- The counters are cleared by rst but not by i_flush.
- When not defined, neither the ports nor the logic exist.

Test Plan:
- Single port 0 mispred, rob {0,5}, npc 0x8000_0100, rdy=1 -> o_redirect_vld=1 the next cycle with rob {0,5}, npc 0x8000_0100; then o_squash_active=1; after i_squash_done, o_squash_active=0.
- Port 0 rob {0,9} and port 1 rob {0,3} mispred in the same cycle -> redirect shows rob {0,3}; {0,9} is never presented.
- Wrap: pending rob {1,2} held with rdy=0, then port 1 rob {0,60} arrives -> pending replaced with {0,60}. Then rob {1,1} arrives -> ignored.
- squash_active with last_rob {0,10}: candidate {0,12} -> dropped; candidate {0,8} -> redirect issued for {0,8}.
- Handshake cycle plus older winner {0,1} against pending {0,4} -> o_redirect_vld stays 1 the next cycle with {0,1}.
- i_flush asserted while in HOLD with a new candidate in the same cycle -> next cycle o_redirect_vld=0, o_squash_active=0, and nothing is issued afterwards.
